// File: rtl/spi_cfg_pkg.sv
// Shared definitions for the SPI configuration sequencer: status bits, table entry layout, FSM states.
// Pure definitions, no logic or latency; imported by every file of the block.
package spi_cfg_pkg;

  localparam int unsigned ST_RESET = 0;
  localparam int unsigned ST_DATA  = 1;
  localparam int unsigned ST_RECE  = 2;
  localparam int unsigned ST_SEND  = 3;
  localparam int unsigned ST_DONE  = 7;

  localparam int unsigned ENTRY_W      = 26;
  localparam int unsigned ENT_B2_LSB   = 0;
  localparam int unsigned ENT_B1_LSB   = 8;
  localparam int unsigned ENT_B0_LSB   = 16;
  localparam int unsigned ENT_RD_BIT   = 24;
  localparam int unsigned ENT_LAST_BIT = 25;

  typedef struct packed {
    logic       last;
    logic       rd;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
  } entry_t;

  typedef enum logic [3:0] {
    S_IDLE, S_RST, S_FETCH, S_LOAD, S_LGAP, S_CHECK, S_SEND, S_WAIT, S_GAP, S_FIN
  } state_t;

  function automatic logic [ENTRY_W-1:0] mk_entry(input logic last, input logic rd,
                                                  input logic [7:0] b0, input logic [7:0] b1,
                                                  input logic [7:0] b2);
    logic [ENTRY_W-1:0] e;
    e                    = '0;
    e[ENT_LAST_BIT]      = last;
    e[ENT_RD_BIT]        = rd;
    e[ENT_B0_LSB +: 8]   = b0;
    e[ENT_B1_LSB +: 8]   = b1;
    e[ENT_B2_LSB +: 8]   = b2;
    return e;
  endfunction

endpackage

// File: rtl/spi_cfg_sequencer_if.sv
// Register-handshake bus between the sequencer (master modport) and the PL SPI master (slave modport).
// Plain wires, no latency; the done bit in i_StatusReg is the only backpressure.
interface spi_cfg_sequencer_if;
  logic [7:0] o_StatusReg;
  logic [7:0] o_TxBuffer;
  logic [7:0] o_Cmd_Lim;
  logic [7:0] i_StatusReg;
  logic [7:0] i_RxBuffer;
  logic [7:0] i_Tx_Cnt;

  modport master (output o_StatusReg, o_TxBuffer, o_Cmd_Lim,
                  input  i_StatusReg, i_RxBuffer, i_Tx_Cnt);
  modport slave  (input  o_StatusReg, o_TxBuffer, o_Cmd_Lim,
                  output i_StatusReg, i_RxBuffer, i_Tx_Cnt);
endinterface

// File: rtl/spi_cfg_rom.sv
// Transaction table ROM: index in, 26-bit entry out, one registered cycle of latency.
// No backpressure; the entry for the index presented before an edge is valid after it.
module spi_cfg_rom
  import spi_cfg_pkg::*;
#(
  parameter int IDX_W   = 4,
  parameter int P_TABLE = 0
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic [IDX_W-1:0] i_Idx,
  output entry_t           o_Entry
);

  entry_t w_entry;

  // Table 0 is the ADC power-up write sequence; table 1 is a single readback probe.
  always_comb begin
    w_entry = '0;
    if (P_TABLE == 0) begin
      case (i_Idx)
        IDX_W'(0): w_entry = mk_entry(1'b0, 1'b0, 8'h00, 8'h00, 8'h3C);
        IDX_W'(1): w_entry = mk_entry(1'b0, 1'b0, 8'h00, 8'h14, 8'h09);
        IDX_W'(2): w_entry = mk_entry(1'b1, 1'b0, 8'h00, 8'hFF, 8'h01);
        default:   w_entry = '0;
      endcase
    end else begin
      case (i_Idx)
        IDX_W'(0): w_entry = mk_entry(1'b1, 1'b1, 8'h80, 8'h01, 8'hA5);
        default:   w_entry = '0;
      endcase
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) o_Entry <= '0;
    else          o_Entry <= w_entry;
  end

endmodule

// File: rtl/spi_cfg_sequencer.sv
// Walks the transaction table and drives the SPI master's status-register handshake; 3-byte load per entry.
// Latency set by the master: waits for its done bit (bounded by TIMEOUT_CYCLES), then GAP_CYCLES idle.
module spi_cfg_sequencer
  import spi_cfg_pkg::*;
#(
  parameter int N_ENTRIES      = 16,
  parameter int IDX_W          = 4,
  parameter int BYTES_PER_CMD  = 3,
  parameter int GAP_CYCLES     = 32,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int P_TABLE        = 0
) (
  input  logic               i_Clk,
  input  logic               i_Rst_n,
  input  logic               i_Start,
  output logic               o_Busy,
  output logic               o_Done,
  output logic               o_Error,
  output logic [7:0]         o_Mismatch_Cnt,
  output logic [IDX_W-1:0]   o_Entry_Idx,
  spi_cfg_sequencer_if.master io_Spi
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam int K_W   = (BYTES_PER_CMD > 1) ? $clog2(BYTES_PER_CMD) : 1;

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic [K_W-1:0]   r_k, w_k_nxt;
  logic [CNT_W-1:0] r_cnt;
  entry_t           r_entry, w_rom_entry;
  logic             r_err;
  logic [7:0]       r_mm;
  logic [7:0]       w_status, w_txbuf, w_byte;
  logic             w_done, w_err_set, w_mm_inc, w_clr;
  logic             w_done_in, w_unused_status;

  assign w_done_in       = io_Spi.i_StatusReg[ST_DONE];
  assign w_unused_status = ^io_Spi.i_StatusReg[6:0];

  // Addressed with the next index so the entry is already valid during FETCH.
  spi_cfg_rom #(.IDX_W(IDX_W), .P_TABLE(P_TABLE)) u_rom (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .i_Idx   (w_idx_nxt),
    .o_Entry (w_rom_entry)
  );

  always_comb begin
    case (r_k)
      K_W'(0):  w_byte = r_entry.b0;
      K_W'(1):  w_byte = r_entry.b1;
      default:  w_byte = r_entry.b2;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_k_nxt     = r_k;
    w_status    = '0;
    w_txbuf     = '0;
    w_done      = 1'b0;
    w_err_set   = 1'b0;
    w_mm_inc    = 1'b0;
    w_clr       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_Start) begin
          w_state_nxt = S_RST;
          w_idx_nxt   = '0;
          w_clr       = 1'b1;
        end
      end
      S_RST: begin
        w_status[ST_RESET] = 1'b1;
        w_state_nxt        = S_FETCH;
      end
      S_FETCH: begin
        w_k_nxt     = '0;
        w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_status[ST_DATA] = 1'b1;
        w_txbuf           = w_byte;
        w_state_nxt       = S_LGAP;
      end
      S_LGAP: begin
        if (r_k < K_W'(BYTES_PER_CMD - 1)) begin
          w_k_nxt     = r_k + K_W'(1);
          w_state_nxt = S_LOAD;
        end else begin
          w_state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        if (io_Spi.i_Tx_Cnt == 8'(BYTES_PER_CMD)) begin
          w_state_nxt = S_SEND;
        end else begin
          w_err_set   = 1'b1;
          w_state_nxt = S_FIN;
        end
      end
      S_SEND: begin
        w_status[ST_SEND] = 1'b1;
        w_status[ST_RECE] = r_entry.rd;
        w_state_nxt       = S_WAIT;
      end
      S_WAIT: begin
        w_status[ST_RECE] = r_entry.rd;
        // First two cycles ignore a done bit left over from the previous transfer.
        if (r_cnt >= CNT_W'(2) && w_done_in) begin
          w_mm_inc    = r_entry.rd && (io_Spi.i_RxBuffer != r_entry.b2);
          w_state_nxt = S_GAP;
        end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          w_err_set   = 1'b1;
          w_state_nxt = S_FIN;
        end
      end
      S_GAP: begin
        if (r_cnt == CNT_W'(GAP_CYCLES - 1)) begin
          if (r_entry.last || r_idx == IDX_W'(N_ENTRIES - 1)) begin
            w_state_nxt = S_FIN;
          end else begin
            w_idx_nxt   = r_idx + IDX_W'(1);
            w_state_nxt = S_FETCH;
          end
        end
      end
      S_FIN: begin
        if (r_err && r_cnt == '0) begin
          w_status[ST_RESET] = 1'b1;
        end else begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // r_cnt restarts on every state change and serves WAIT, GAP and FIN.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_idx   <= '0;
      r_k     <= '0;
      r_cnt   <= '0;
      r_entry <= '0;
      r_err   <= 1'b0;
      r_mm    <= '0;
    end else begin
      r_idx <= w_idx_nxt;
      r_k   <= w_k_nxt;
      r_cnt <= (w_state_nxt != r_state) ? '0 : r_cnt + CNT_W'(1);
      if (r_state == S_FETCH) r_entry <= w_rom_entry;
      if (w_clr) begin
        r_err <= 1'b0;
        r_mm  <= '0;
      end else begin
        if (w_err_set) r_err <= 1'b1;
        if (w_mm_inc && r_mm != 8'hFF) r_mm <= r_mm + 8'd1;
      end
    end
  end

  assign o_Busy             = (r_state != S_IDLE);
  assign o_Done             = w_done;
  assign o_Error            = r_err;
  assign o_Mismatch_Cnt     = r_mm;
  assign o_Entry_Idx        = r_idx;
  assign io_Spi.o_StatusReg = w_status;
  assign io_Spi.o_TxBuffer  = w_txbuf;
  assign io_Spi.o_Cmd_Lim   = 8'(BYTES_PER_CMD);

endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// Directed bench: two sequencers (write table, read table) each driven by a small SPI master model.
module tb_spi_cfg_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start      [2];
  logic       obs_busy   [2];
  logic       obs_done   [2];
  logic       obs_err    [2];
  logic [7:0] obs_mm     [2];
  logic [3:0] obs_idx    [2];
  logic [7:0] obs_status [2];
  logic [7:0] obs_txbuf  [2];
  logic [7:0] obs_cmdlim [2];

  // master model state and knobs
  logic       bfm_done [2];
  logic       bfm_run  [2];
  logic [7:0] tx_cnt   [2];
  int         bcnt     [2];
  int         delay    [2];
  logic       never    [2];
  logic       stale    [2];
  logic       cap2     [2];
  logic [7:0] rx_val   [2];

  spi_cfg_sequencer_if u_if0 ();
  spi_cfg_sequencer_if u_if1 ();

  spi_cfg_sequencer #(.P_TABLE(0)) u_dut0 (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Start(start[0]), .o_Busy(obs_busy[0]), .o_Done(obs_done[0]),
    .o_Error(obs_err[0]), .o_Mismatch_Cnt(obs_mm[0]), .o_Entry_Idx(obs_idx[0]), .io_Spi(u_if0.master)
  );
  spi_cfg_sequencer #(.P_TABLE(1)) u_dut1 (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Start(start[1]), .o_Busy(obs_busy[1]), .o_Done(obs_done[1]),
    .o_Error(obs_err[1]), .o_Mismatch_Cnt(obs_mm[1]), .o_Entry_Idx(obs_idx[1]), .io_Spi(u_if1.master)
  );

  assign obs_status[0] = u_if0.o_StatusReg;
  assign obs_txbuf[0]  = u_if0.o_TxBuffer;
  assign obs_cmdlim[0] = u_if0.o_Cmd_Lim;
  assign obs_status[1] = u_if1.o_StatusReg;
  assign obs_txbuf[1]  = u_if1.o_TxBuffer;
  assign obs_cmdlim[1] = u_if1.o_Cmd_Lim;

  assign u_if0.i_StatusReg = {bfm_done[0], 7'b0};
  assign u_if0.i_RxBuffer  = rx_val[0];
  assign u_if0.i_Tx_Cnt    = tx_cnt[0];
  assign u_if1.i_StatusReg = {bfm_done[1], 7'b0};
  assign u_if1.i_RxBuffer  = rx_val[1];
  assign u_if1.i_Tx_Cnt    = tx_cnt[1];

  // Master model: counts Data strobes, raises done 'delay' cycles after Send.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < 2; g++) begin
        tx_cnt[g] <= '0; bfm_done[g] <= 1'b0; bfm_run[g] <= 1'b0; bcnt[g] <= 0;
      end
    end else begin
      for (int g = 0; g < 2; g++) begin
        if (obs_status[g][0]) begin
          tx_cnt[g] <= '0; bfm_done[g] <= 1'b0; bfm_run[g] <= 1'b0;
        end else if (obs_status[g][3]) begin
          tx_cnt[g]   <= '0;
          bfm_run[g]  <= !never[g];
          bcnt[g]     <= 1;
          bfm_done[g] <= stale[g];
        end else begin
          if (obs_status[g][1] && !(cap2[g] && tx_cnt[g] >= 8'd2)) tx_cnt[g] <= tx_cnt[g] + 8'd1;
          if (bfm_run[g]) begin
            bcnt[g] <= bcnt[g] + 1;
            if (stale[g] && bcnt[g] == 2) bfm_done[g] <= 1'b0;
            if (bcnt[g] == delay[g]) begin
              bfm_done[g] <= 1'b1; bfm_run[g] <= 1'b0;
            end
          end
        end
      end
    end
  end

  int         cyc = 0;
  int         n_data [2], n_pairs [2], n_consec [2], n_send [2], n_rst [2], n_rece [2], n_done [2];
  int         last_data [2], t_send [2], t_rst [2], t_done [2], tx_n [2];
  logic [7:0] send_val [2];
  logic [7:0] tx_log [2][128];

  initial begin
    for (int g = 0; g < 2; g++) begin
      n_data[g] = 0; n_pairs[g] = 0; n_consec[g] = 0; n_send[g] = 0; n_rst[g] = 0;
      n_rece[g] = 0; n_done[g] = 0; last_data[g] = -10; t_send[g] = 0; t_rst[g] = 0;
      t_done[g] = 0; tx_n[g] = 0; send_val[g] = '0;
    end
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    for (int g = 0; g < 2; g++) begin
      if (obs_status[g][1]) begin
        n_data[g] <= n_data[g] + 1;
        if (cyc - last_data[g] == 1) n_consec[g] <= n_consec[g] + 1;
        if (cyc - last_data[g] == 2) n_pairs[g] <= n_pairs[g] + 1;
        last_data[g] <= cyc;
        tx_log[g][tx_n[g] & 127] <= obs_txbuf[g];
        tx_n[g] <= tx_n[g] + 1;
      end
      if (obs_status[g][3]) begin
        n_send[g] <= n_send[g] + 1; send_val[g] <= obs_status[g]; t_send[g] <= cyc;
      end
      if (obs_status[g] == 8'h01) begin
        n_rst[g] <= n_rst[g] + 1; t_rst[g] <= cyc;
      end
      if (obs_status[g][2]) n_rece[g] <= n_rece[g] + 1;
      if (obs_done[g]) begin
        n_done[g] <= n_done[g] + 1; t_done[g] <= cyc;
      end
    end
  end

  int n_chk = 0;
  int n_pass = 0;
  int b_data, b_pairs, b_consec, b_send, b_rst, b_rece, b_done, b_tx;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic snap(input int g);
    b_data = n_data[g]; b_pairs = n_pairs[g]; b_consec = n_consec[g]; b_send = n_send[g];
    b_rst = n_rst[g]; b_rece = n_rece[g]; b_done = n_done[g]; b_tx = tx_n[g];
  endtask

  task automatic do_start(input int g);
    snap(g);
    @(negedge clk); start[g] = 1'b1;
    @(negedge clk); start[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int budget, input string tag);
    bit got;
    int i;
    got = 1'b0;
    i = 0;
    while (!got && i < budget) begin
      @(negedge clk);
      if (obs_done[g]) got = 1'b1;
      i++;
    end
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    bit reached;
    int i;
    for (int g = 0; g < 2; g++) begin
      start[g] = 1'b0; delay[g] = 100; never[g] = 1'b0; stale[g] = 1'b0; cap2[g] = 1'b0;
      rx_val[g] = 8'h00;
    end
    repeat (3) @(negedge clk);
    chk("rst_busy",   32'(obs_busy[0]),   32'd0);
    chk("rst_done",   32'(obs_done[0]),   32'd0);
    chk("rst_err",    32'(obs_err[0]),    32'd0);
    chk("rst_mm",     32'(obs_mm[0]),     32'd0);
    chk("rst_idx",    32'(obs_idx[0]),    32'd0);
    chk("rst_status", 32'(obs_status[0]), 32'd0);
    chk("rst_txbuf",  32'(obs_txbuf[0]),  32'd0);
    chk("rst_cmdlim", 32'(obs_cmdlim[0]), 32'd3);
    chk("rst_cmdlim1",32'(obs_cmdlim[1]), 32'd3);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // three writes, done 100 cycles after Send
    do_start(0);
    wait_done(0, 3000, "wr");
    chk("wr_data",    32'(n_data[0] - b_data),     32'd9);
    chk("wr_pairs",   32'(n_pairs[0] - b_pairs),   32'd6);
    chk("wr_consec",  32'(n_consec[0] - b_consec), 32'd0);
    chk("wr_send",    32'(n_send[0] - b_send),     32'd3);
    chk("wr_sendval", 32'(send_val[0]),            32'h08);
    chk("wr_rst",     32'(n_rst[0] - b_rst),       32'd1);
    chk("wr_done",    32'(n_done[0] - b_done),     32'd1);
    chk("wr_rece",    32'(n_rece[0] - b_rece),     32'd0);
    chk("wr_err",     32'(obs_err[0]),             32'd0);
    chk("wr_idx",     32'(obs_idx[0]),             32'd2);
    chk("wr_busy",    32'(obs_busy[0]),            32'd0);
    chk("wr_byte2",   32'(tx_log[0][(b_tx + 2) & 127]), 32'h3C);
    chk("wr_byte4",   32'(tx_log[0][(b_tx + 4) & 127]), 32'h14);
    chk("wr_byte8",   32'(tx_log[0][(b_tx + 8) & 127]), 32'h01);

    // read with matching data, then with mismatching data
    delay[1] = 20; rx_val[1] = 8'hA5;
    do_start(1);
    wait_done(1, 1000, "rd");
    chk("rd_mm",      32'(obs_mm[1]),              32'd0);
    chk("rd_rece",    32'(n_rece[1] - b_rece),     32'd22);
    chk("rd_sendval", 32'(send_val[1]),            32'h0C);
    chk("rd_err",     32'(obs_err[1]),             32'd0);
    chk("rd_byte0",   32'(tx_log[1][b_tx & 127]),  32'h80);
    rx_val[1] = 8'h5A;
    do_start(1);
    wait_done(1, 1000, "rd2");
    chk("rd2_mm",     32'(obs_mm[1]),              32'd1);

    // done never comes
    never[1] = 1'b1;
    do_start(1);
    wait_done(1, 6000, "to");
    chk("to_err",     32'(obs_err[1]),             32'd1);
    chk("to_rst",     32'(n_rst[1] - b_rst),       32'd2);
    chk("to_wait",    32'(t_rst[1] - t_send[1]),   32'd4097);
    chk("to_fin",     32'(t_done[1] - t_rst[1]),   32'd1);
    never[1] = 1'b0; rx_val[1] = 8'hA5;
    do_start(1);
    chk("to_clr",     32'(obs_err[1]),             32'd0);
    wait_done(1, 1000, "to2");
    chk("to2_err",    32'(obs_err[1]),             32'd0);

    // master reports only two bytes loaded
    cap2[0] = 1'b1;
    do_start(0);
    wait_done(0, 500, "sh");
    chk("sh_err",     32'(obs_err[0]),             32'd1);
    chk("sh_send",    32'(n_send[0] - b_send),     32'd0);
    chk("sh_data",    32'(n_data[0] - b_data),     32'd3);
    chk("sh_rst",     32'(n_rst[0] - b_rst),       32'd2);
    chk("sh_idx",     32'(obs_idx[0]),             32'd0);
    cap2[0] = 1'b0;

    // done still high from before the Send, inside the blanking window
    stale[1] = 1'b1; delay[1] = 10;
    do_start(1);
    wait_done(1, 1000, "st");
    chk("st_rece",    32'(n_rece[1] - b_rece),     32'd12);
    chk("st_mm",      32'(obs_mm[1]),              32'd0);
    chk("st_err",     32'(obs_err[1]),             32'd0);
    stale[1] = 1'b0;

    // asynchronous reset during the first Data strobe of entry 1
    delay[0] = 20;
    do_start(0);
    reached = 1'b0;
    i = 0;
    while (!reached && i < 1000) begin
      @(negedge clk);
      if (obs_idx[0] == 4'd1 && obs_status[0] == 8'h02) reached = 1'b1;
      i++;
    end
    chk("ar_reach", 32'(reached), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_busy",    32'(obs_busy[0]),            32'd0);
    chk("ar_status",  32'(obs_status[0]),          32'd0);
    chk("ar_idx",     32'(obs_idx[0]),             32'd0);
    chk("ar_txbuf",   32'(obs_txbuf[0]),           32'd0);
    chk("ar_cmdlim",  32'(obs_cmdlim[0]),          32'd3);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    do_start(0);
    chk("ar_first_status", 32'(obs_status[0]),     32'h01);
    chk("ar_first_idx",    32'(obs_idx[0]),        32'd0);
    wait_done(0, 3000, "ar");
    chk("ar_data",    32'(n_data[0] - b_data),     32'd9);
    chk("ar_idx_end", 32'(obs_idx[0]),             32'd2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
